// File: rtl/collatz_pkg.sv
// Shared widths and the scan controller state encoding for the collatz sweep blocks.
package collatz_pkg;
  localparam int N_W     = 32;
  localparam int COUNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    READ,
    DRAIN,
    FINISH
  } scan_state_t;
endpackage

// File: rtl/range_max_scan_if.sv
// Host-side control/result bus of range_max_scan.
interface range_max_scan_if;
  import collatz_pkg::*;

  logic               go;
  logic [N_W-1:0]     base;
  logic               busy;
  logic               done;
  logic [N_W-1:0]     best_n;
  logic [COUNT_W-1:0] best_count;

  modport master (output go, base, input busy, done, best_n, best_count);
  modport slave  (input go, base, output busy, done, best_n, best_count);
endinterface

// File: rtl/max_tracker.sv
// Running maximum over (key, value) pairs; strict-greater update keeps the earliest key on ties.
module max_tracker
  import collatz_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               valid,
  input  logic               first,
  input  logic [N_W-1:0]     key,
  input  logic [COUNT_W-1:0] value,
  output logic [N_W-1:0]     best_key,
  output logic [COUNT_W-1:0] best_value
);
  logic [N_W-1:0]     r_best_key;
  logic [COUNT_W-1:0] r_best_value;

  // The first pair is always taken so an all-zero sweep still reports its first key.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_best_key   <= '0;
      r_best_value <= '0;
    end else if (valid && (first || (value > r_best_value))) begin
      r_best_key   <= key;
      r_best_value <= value;
    end
  end

  assign best_key   = r_best_key;
  assign best_value = r_best_value;
endmodule

// File: rtl/range_max_scan.sv
// Launches one range sweep, reads its counts back one per cycle and reports the start
// value with the largest count.
module range_max_scan
  import collatz_pkg::*;
#(
  parameter int RAM_WORDS     = 16,
  parameter int RAM_ADDR_BITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  range_max_scan_if.slave    bus,
  output logic               rgo,
  output logic [N_W-1:0]     rstart,
  input  logic               rdone,
  input  logic [COUNT_W-1:0] rcount
);
  scan_state_t              r_state;
  scan_state_t              w_state_next;
  logic [N_W-1:0]           r_base;
  logic [RAM_ADDR_BITS:0]   r_idx;
  logic                     r_vld_d;
  logic [RAM_ADDR_BITS-1:0] r_idx_d;
  logic                     w_go_acc;
  logic                     w_last;
  logic [N_W-1:0]           w_best_n;
  logic [COUNT_W-1:0]       w_best_count;

  assign w_go_acc = (r_state == IDLE) && bus.go;
  assign w_last   = (r_idx == (RAM_ADDR_BITS+1)'(RAM_WORDS - 1));

  always_comb begin
    w_state_next = r_state;
    rstart       = '0;
    case (r_state)
      IDLE:   if (bus.go) w_state_next = LAUNCH;
      LAUNCH: begin
        rstart       = r_base;
        w_state_next = WAIT;
      end
      WAIT: begin
        rstart = r_base;
        if (rdone) w_state_next = READ;
      end
      READ: begin
        rstart = N_W'(r_idx);
        if (w_last) w_state_next = DRAIN;
      end
      DRAIN:  w_state_next = FINISH;
      FINISH: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Valid/index are delayed one cycle to line up with range's registered read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_base  <= '0;
      r_idx   <= '0;
      r_vld_d <= 1'b0;
      r_idx_d <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_go_acc) r_base <= bus.base;
      if (r_state == WAIT) r_idx <= '0;
      else if (r_state == READ) r_idx <= r_idx + 1'b1;
      r_vld_d <= (r_state == READ);
      r_idx_d <= r_idx[RAM_ADDR_BITS-1:0];
    end
  end

  max_tracker u_tracker (
    .clk        (clk),
    .reset      (reset),
    .clear      (w_go_acc),
    .valid      (r_vld_d),
    .first      (r_idx_d == '0),
    .key        (r_base + N_W'(r_idx_d)),
    .value      (rcount),
    .best_key   (w_best_n),
    .best_value (w_best_count)
  );

  assign rgo            = (r_state == LAUNCH);
  assign bus.busy       = (r_state != IDLE);
  assign bus.done       = (r_state == FINISH);
  assign bus.best_n     = w_best_n;
  assign bus.best_count = w_best_count;
endmodule

// File: tb/tb_range_max_scan.sv
// Table-driven bench for range_max_scan with a stub range (registered read, rdone 5 cycles after rgo).
module tb_range_max_scan;
  import collatz_pkg::*;

  localparam int RW = 16;

  typedef struct {
    logic [31:0]       base;
    logic [15:0][15:0] cnt;
    logic [31:0]       exp_n;
    logic [15:0]       exp_c;
  } vec_t;

  typedef struct {
    logic [31:0] n;
    logic [15:0] c;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        rgo;
  logic [31:0] rstart;
  logic        rdone;
  logic [15:0] rcount;

  always #5 clk = ~clk;

  range_max_scan_if bus();

  range_max_scan #(.RAM_WORDS(16), .RAM_ADDR_BITS(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus.slave),
    .rgo    (rgo),
    .rstart (rstart),
    .rdone  (rdone),
    .rcount (rcount)
  );

  // Stub range
  logic [15:0] mem [RW];
  int          stub_cnt = 0;
  logic        inj_rdone;
  logic        real_rdone;

  always @(posedge clk) begin
    rcount <= mem[rstart[3:0]];
    if (rgo) stub_cnt <= 5;
    else if (stub_cnt > 0) stub_cnt <= stub_cnt - 1;
  end
  assign real_rdone = (stub_cnt == 1);
  assign rdone      = real_rdone | inj_rdone;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   t_rdone = 0;
  int   n_done  = 0;
  int   n_rgo   = 0;
  exp_t sb[$];
  exp_t e;
  vec_t vec[7];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (real_rdone) t_rdone = cyc;
    if (rgo) n_rgo++;
    if (bus.done === 1'b1 && !reset) begin
      n_done++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want no done");
      end else begin
        e = sb.pop_front();
        $display("txn: best_n=%h best_count=%0d (want %h/%0d)", bus.best_n, bus.best_count, e.n, e.c);
        check("best_n", bus.best_n, e.n);
        check("best_count", 32'(bus.best_count), 32'(e.c));
        check("rdone_to_done", cyc - t_rdone, RW + 2);
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic launch(logic [31:0] b, logic [31:0] en, logic [15:0] ec);
    exp_t x;
    x.n = en;
    x.c = ec;
    sb.push_back(x);
    bus.go   = 1'b1;
    bus.base = b;
    tick();
    bus.go = 1'b0;
  endtask

  task automatic wait_done(int start_cnt);
    int k = 0;
    while (n_done == start_cnt && k < 300) begin
      tick();
      k++;
    end
    if (n_done == start_cnt) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done want done within 300 cycles");
    end
  endtask

  task automatic load(int v);
    for (int i = 0; i < RW; i++) mem[i] = vec[v].cnt[i];
  endtask

  initial begin
    int n0;
    int r0;
    bus.go    = 1'b0;
    bus.base  = '0;
    inj_rdone = 1'b0;
    reset     = 1'b1;
    for (int i = 0; i < RW; i++) mem[i] = '0;

    // Vector table
    vec[0].base = 32'd100; vec[0].cnt = '0;
    vec[0].cnt[0] = 16'd3; vec[0].cnt[1] = 16'd9; vec[0].cnt[2] = 16'd9; vec[0].cnt[3] = 16'd2;
    vec[0].exp_n = 32'd101; vec[0].exp_c = 16'd9;

    vec[1].base = 32'hFFFF_FFF8; vec[1].cnt = '0; vec[1].cnt[12] = 16'd5;
    vec[1].exp_n = 32'h0000_0004; vec[1].exp_c = 16'd5;

    vec[2].base = 32'd55; vec[2].cnt = '0;
    vec[2].exp_n = 32'd55; vec[2].exp_c = 16'd0;

    // Collatz step counts for start values 1..16
    vec[3].base = 32'd1;
    vec[3].cnt[0] = 16'd0;   vec[3].cnt[1] = 16'd1;   vec[3].cnt[2] = 16'd7;   vec[3].cnt[3] = 16'd2;
    vec[3].cnt[4] = 16'd5;   vec[3].cnt[5] = 16'd8;   vec[3].cnt[6] = 16'd16;  vec[3].cnt[7] = 16'd3;
    vec[3].cnt[8] = 16'd19;  vec[3].cnt[9] = 16'd6;   vec[3].cnt[10] = 16'd14; vec[3].cnt[11] = 16'd9;
    vec[3].cnt[12] = 16'd9;  vec[3].cnt[13] = 16'd17; vec[3].cnt[14] = 16'd17; vec[3].cnt[15] = 16'd4;
    vec[3].exp_n = 32'd9; vec[3].exp_c = 16'd19;

    vec[4].base = 32'd0;
    for (int i = 0; i < RW; i++) vec[4].cnt[i] = 16'd1;
    vec[4].cnt[15] = 16'hFFFF;
    vec[4].exp_n = 32'd15; vec[4].exp_c = 16'hFFFF;

    vec[5].base = 32'd200;
    for (int i = 0; i < RW; i++) vec[5].cnt[i] = 16'd7;
    vec[5].exp_n = 32'd200; vec[5].exp_c = 16'd7;

    vec[6].base = 32'h10;
    for (int i = 0; i < RW; i++) vec[6].cnt[i] = 16'(i);
    vec[6].exp_n = 32'h1F; vec[6].exp_c = 16'd15;

    // Reset state
    tick(3);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_rgo", 32'(rgo), 0);
    check("rst_rstart", rstart, 0);
    check("rst_best_n", bus.best_n, 0);
    check("rst_best_count", 32'(bus.best_count), 0);
    reset = 1'b0;
    tick();

    // Table-driven sweeps
    for (int v = 0; v < 7; v++) begin
      load(v);
      n0 = n_done;
      r0 = n_rgo;
      launch(vec[v].base, vec[v].exp_n, vec[v].exp_c);
      wait_done(n0);
      check("rgo_pulses", n_rgo - r0, 1);
    end

    // go held high during WAIT/READ plus a spurious rdone in READ
    load(0);
    n0 = n_done;
    r0 = n_rgo;
    launch(32'd100, 32'd101, 16'd9);
    bus.go   = 1'b1;
    bus.base = 32'hDEAD_BEEF;
    tick(9);
    inj_rdone = 1'b1;
    tick();
    inj_rdone = 1'b0;
    tick(4);
    bus.go = 1'b0;
    wait_done(n0);
    tick(30);
    check("single_done", n_done - n0, 1);
    check("single_rgo", n_rgo - r0, 1);

    // Reset during READ, then a fresh sweep
    load(1);
    launch(32'hFFFF_FFF8, 32'h4, 16'd5);
    tick(8);
    reset = 1'b1;
    tick();
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_done", 32'(bus.done), 0);
    check("mid_rst_best_count", 32'(bus.best_count), 0);
    check("mid_rst_best_n", bus.best_n, 0);
    reset = 1'b0;
    sb.delete();
    tick();
    for (int i = 0; i < RW; i++) mem[i] = '0;
    mem[3]  = 16'd40;
    mem[10] = 16'd40;
    n0 = n_done;
    launch(32'd7, 32'd10, 16'd40);
    wait_done(n0);

    // Back-to-back: go in the cycle after done
    load(0);
    n0 = n_done;
    launch(32'd100, 32'd101, 16'd9);
    wait_done(n0);
    check("hold_best_n", bus.best_n, 32'd101);
    load(6);
    n0 = n_done;
    launch(32'h10, 32'h1F, 16'd15);
    check("b2b_busy", 32'(bus.busy), 1);
    check("b2b_cleared_count", 32'(bus.best_count), 0);
    check("b2b_cleared_n", bus.best_n, 0);
    wait_done(n0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
